// File: rtl/writeback_stage.sv
// Writeback stage: merges a priority ALU lane and a FIFO-buffered long-latency lane
// into one registered register-file write port, with a pending-write scoreboard.
module writeback_stage #(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          alu_valid,
  input  logic                          alu_we,
  input  logic [4:0]                    alu_rd,
  input  logic [XLEN-1:0]               alu_data,
  output logic                          alu_stall,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic                          mem_we,
  input  logic [4:0]                    mem_rd,
  input  logic [XLEN-1:0]               mem_data,
  input  logic [4:0]                    q_rs1,
  input  logic [4:0]                    q_rs2,
  output logic                          q_hit1,
  output logic                          q_hit2,
  output logic                          reg_write,
  output logic [4:0]                    write_reg,
  output logic [XLEN-1:0]               write_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          waw_conflict
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]            ent_rd   [FIFO_DEPTH];
  logic [XLEN-1:0]       ent_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] ent_vld;
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count;
  logic [SW-1:0]         starve;
  logic                  live;

  logic alu_eff;
  logic push;
  logic pop;
  logic fifo_hit1;
  logic fifo_hit2;
  logic fifo_waw;

  assign alu_eff    = alu_valid && alu_we && (alu_rd != 5'd0) && !alu_stall;
  // live keeps mem_ready low until the first edge after reset release
  assign mem_ready  = live && (count < CW'(FIFO_DEPTH));
  assign push       = mem_valid && mem_ready && mem_we && (mem_rd != 5'd0);
  assign pop        = !alu_eff && (count != '0);
  assign fifo_count = count;

  always_comb begin
    fifo_hit1 = 1'b0;
    fifo_hit2 = 1'b0;
    fifo_waw  = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_vld[i]) begin
        if (ent_rd[i] == q_rs1) fifo_hit1 = 1'b1;
        if (ent_rd[i] == q_rs2) fifo_hit2 = 1'b1;
        if (ent_rd[i] == alu_rd) fifo_waw = 1'b1;
      end
    end
  end

  assign q_hit1 = (q_rs1 != 5'd0) &&
                  (fifo_hit1 || (reg_write && write_reg == q_rs1));
  assign q_hit2 = (q_rs2 != 5'd0) &&
                  (fifo_hit2 || (reg_write && write_reg == q_rs2));

  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd[tail]   <= mem_rd;
      ent_data[tail] <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent_vld <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      live    <= 1'b0;
    end else begin
      live <= 1'b1;
      if (pop) begin
        ent_vld[head] <= 1'b0;
        head          <= head + PW'(1);
      end
      if (push) begin
        ent_vld[tail] <= 1'b1;
        tail          <= tail + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // stall the ALU for one cycle once the head has been blocked STARVE_LIMIT times
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve    <= '0;
      alu_stall <= 1'b0;
    end else begin
      if (pop || count == '0) starve <= '0;
      else if (alu_eff)        starve <= starve + SW'(1);
      alu_stall <= alu_eff && (count != '0) &&
                   (starve == SW'(STARVE_LIMIT - 1));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_write    <= 1'b0;
      write_reg    <= '0;
      write_data   <= '0;
      waw_conflict <= 1'b0;
    end else begin
      waw_conflict <= alu_eff && fifo_waw;
      if (alu_eff) begin
        reg_write  <= 1'b1;
        write_reg  <= alu_rd;
        write_data <= alu_data;
      end else if (count != '0) begin
        reg_write  <= 1'b1;
        write_reg  <= ent_rd[head];
        write_data <= ent_data[head];
      end else begin
        reg_write  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed-vector bench for writeback_stage.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid, alu_we;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        mem_valid, mem_ready, mem_we;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic [4:0]  q_rs1, q_rs2;
  logic        q_hit1, q_hit2;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [1:0]  fifo_count;
  logic        waw_conflict;

  int n_vec = 0;
  int n_err = 0;

  writeback_stage #(.XLEN(32), .FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_we(alu_we),
    .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_rd(mem_rd), .mem_data(mem_data),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_hit1(q_hit1), .q_hit2(q_hit2),
    .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .fifo_count(fifo_count),
    .waw_conflict(waw_conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic v, input logic [4:0] rd,
                     input logic [31:0] d);
    alu_valid = v;
    alu_we    = v;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  task automatic mem(input logic v, input logic we,
                     input logic [4:0] rd, input logic [31:0] d);
    mem_valid = v;
    mem_we    = we;
    mem_rd    = rd;
    mem_data  = d;
  endtask

  initial begin
    reset_n = 1'b0;
    alu(0, 0, 0);
    mem(0, 0, 0, 0);
    q_rs1 = 0;
    q_rs2 = 0;
    #12;
    check("rst_reg_write", 32'(reg_write), 32'd0);
    check("rst_write_reg", 32'(write_reg), 32'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_alu_stall", 32'(alu_stall), 32'd0);
    check("rst_waw", 32'(waw_conflict), 32'd0);
    reset_n = 1'b1;
    #1;
    check("rel_mem_ready_pre_edge", 32'(mem_ready), 32'd0);

    // ALU single write
    alu(1, 5, 32'hDEADBEEF);
    step();
    check("alu_ready_after_edge", 32'(mem_ready), 32'd1);
    check("alu_we1", 32'(reg_write), 32'd1);
    check("alu_rd1", 32'(write_reg), 32'd5);
    check("alu_d1", write_data, 32'hDEADBEEF);
    alu(0, 0, 0);
    step();
    check("alu_we2", 32'(reg_write), 32'd0);
    check("alu_rd_hold", 32'(write_reg), 32'd5);

    // two long-lane pushes back to back
    mem(1, 1, 3, 32'h11);
    step();
    check("ll_count_a", 32'(fifo_count), 32'd1);
    check("ll_ready_a", 32'(mem_ready), 32'd1);
    check("ll_we_a", 32'(reg_write), 32'd0);
    mem(1, 1, 4, 32'h22);
    step();
    check("ll_count_b", 32'(fifo_count), 32'd1);
    check("ll_ready_b", 32'(mem_ready), 32'd1);
    check("ll_rd_b", 32'(write_reg), 32'd3);
    check("ll_d_b", write_data, 32'h11);
    mem(0, 0, 0, 0);
    step();
    check("ll_count_c", 32'(fifo_count), 32'd0);
    check("ll_we_c", 32'(reg_write), 32'd1);
    check("ll_rd_c", 32'(write_reg), 32'd4);
    check("ll_d_c", write_data, 32'h22);
    step();
    check("ll_we_d", 32'(reg_write), 32'd0);

    // starvation: one entry rd=7 blocked by ALU writes
    mem(1, 1, 7, 32'h77);
    step();
    mem(0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      alu(1, 1, 32'(k));
      step();
      check("st_alu_rd", 32'(write_reg), 32'd1);
      check("st_alu_d", write_data, 32'(k));
      check("st_count", 32'(fifo_count), 32'd1);
      check("st_stall", 32'(alu_stall), (k == 4) ? 32'd1 : 32'd0);
    end
    alu(1, 2, 32'h555);
    step();
    check("st_pop_rd", 32'(write_reg), 32'd7);
    check("st_pop_d", write_data, 32'h77);
    check("st_stall_off", 32'(alu_stall), 32'd0);
    check("st_count0", 32'(fifo_count), 32'd0);
    alu(0, 0, 0);
    step();
    check("st_dropped", 32'(reg_write), 32'd0);

    // full FIFO refuses pushes while ALU blocks
    alu(1, 1, 32'hA1);
    mem(1, 1, 12, 32'h12);
    step();
    mem(1, 1, 13, 32'h13);
    step();
    check("full_count", 32'(fifo_count), 32'd2);
    check("full_ready", 32'(mem_ready), 32'd0);
    mem(1, 1, 14, 32'h14);
    step();
    check("full_nopush", 32'(fifo_count), 32'd2);
    step();
    step();
    check("full_stall", 32'(alu_stall), 32'd1);
    step();
    check("full_pop_rd", 32'(write_reg), 32'd12);
    check("full_count1", 32'(fifo_count), 32'd1);
    check("full_ready1", 32'(mem_ready), 32'd1);
    step();
    check("full_push14", 32'(fifo_count), 32'd2);
    check("full_alu_rd", 32'(write_reg), 32'd1);
    alu(0, 0, 0);
    mem(0, 0, 0, 0);
    step();
    check("full_pop13", 32'(write_reg), 32'd13);
    step();
    check("full_pop14_rd", 32'(write_reg), 32'd14);
    check("full_pop14_d", write_data, 32'h14);
    check("full_empty", 32'(fifo_count), 32'd0);
    step();

    // scoreboard and waw
    alu(1, 1, 32'hB1);
    mem(1, 1, 9, 32'h99);
    step();
    mem(0, 0, 0, 0);
    alu(0, 0, 0);
    q_rs1 = 9;
    q_rs2 = 0;
    #1;
    check("sb_hit_fifo", 32'(q_hit1), 32'd1);
    check("sb_x0", 32'(q_hit2), 32'd0);
    q_rs1 = 8;
    q_rs2 = 1;
    #1;
    check("sb_miss", 32'(q_hit1), 32'd0);
    check("sb_hit_out", 32'(q_hit2), 32'd1);
    alu(1, 9, 32'hC9);
    step();
    check("waw_pulse", 32'(waw_conflict), 32'd1);
    check("waw_data", write_data, 32'hC9);
    check("waw_kept", 32'(fifo_count), 32'd1);
    alu(0, 0, 0);
    mem(1, 1, 0, 32'hEE);
    step();
    check("waw_clear", 32'(waw_conflict), 32'd0);
    check("x0_pop_rd", 32'(write_reg), 32'd9);
    check("x0_pop_d", write_data, 32'h99);
    check("x0_not_stored", 32'(fifo_count), 32'd0);
    mem(0, 0, 0, 0);
    step();
    check("x0_no_write", 32'(reg_write), 32'd0);

    // asynchronous reset mid-operation
    alu(1, 1, 32'hD1);
    mem(1, 1, 20, 32'h20);
    step();
    mem(1, 1, 21, 32'h21);
    step();
    check("mr_count2", 32'(fifo_count), 32'd2);
    check("mr_we", 32'(reg_write), 32'd1);
    alu(0, 0, 0);
    mem(0, 0, 0, 0);
    #1;
    reset_n = 1'b0;
    #1;
    check("mr_we0", 32'(reg_write), 32'd0);
    check("mr_rd0", 32'(write_reg), 32'd0);
    check("mr_d0", write_data, 32'd0);
    check("mr_cnt0", 32'(fifo_count), 32'd0);
    check("mr_ready0", 32'(mem_ready), 32'd0);
    check("mr_stall0", 32'(alu_stall), 32'd0);
    #10;
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("mr_no_stale", 32'(reg_write), 32'd0);
      check("mr_empty", 32'(fifo_count), 32'd0);
    end
    check("mr_ready1", 32'(mem_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
